// File: rtl/uart_cmd_rx_if.sv
// uart_cmd_rx_if: serial line in, received command byte and status out.
// The master drives rx; the receiver (slave) returns the byte and pulses.
interface uart_cmd_rx_if;
   logic       rx;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       busy;

   modport master (
      output rx,
      input  data_out,
      input  data_valid,
      input  frame_err,
      input  busy
   );

   modport slave (
      input  rx,
      output data_out,
      output data_valid,
      output frame_err,
      output busy
   );
endinterface

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 LSB-first UART receiver producing the command byte.
// rx is double-synchronised; start and stop bits are sampled mid-bit.
module uart_cmd_rx #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic           clk,
   input  logic           reset,
   uart_cmd_rx_if.slave   bus
);

   localparam int HALF_BIT = CLKS_PER_BIT / 2;
   localparam int CW       = $clog2(CLKS_PER_BIT);

   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [1:0]    sync;
   logic          rx_s;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic [7:0]    data_q;
   logic          dv_q;
   logic          fe_q;
   logic          expiry;
   logic          dv_nxt;
   logic          fe_nxt;
   logic          busy_c;

   assign rx_s   = sync[1];
   assign expiry = (state == S_START) ? (cnt == HALF_LAST)
                                      : (cnt == FULL_LAST);

   // State register; reset aborts any frame in progress.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode driven by the synchronised line and bit timer.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (!rx_s) state_nxt = S_START;
         S_START: if (expiry) state_nxt = rx_s ? S_IDLE : S_DATA;
         S_DATA:  if (expiry && bit_idx == 3'd7) state_nxt = S_STOP;
         S_STOP:  if (expiry) state_nxt = rx_s ? S_IDLE : S_BREAK;
         S_BREAK: if (rx_s) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output decode: frame result at the mid stop-bit sample, busy flag.
   always_comb begin
      dv_nxt = 1'b0;
      fe_nxt = 1'b0;
      busy_c = (state != S_IDLE);
      if (state == S_STOP && expiry) begin
         dv_nxt = rx_s;
         fe_nxt = !rx_s;
      end
   end

   // Datapath: synchroniser, bit timer, shift register and held byte.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync    <= 2'b11;
         cnt     <= '0;
         bit_idx <= 3'd0;
         shift   <= 8'h00;
         data_q  <= 8'h00;
         dv_q    <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         sync <= {sync[0], bus.rx};
         dv_q <= dv_nxt;
         fe_q <= fe_nxt;
         if (state == S_IDLE || state == S_BREAK)
            cnt <= '0;
         else if (expiry)
            cnt <= '0;
         else
            cnt <= cnt + CW'(1);
         if (state == S_START && expiry)
            bit_idx <= 3'd0;
         else if (state == S_DATA && expiry && bit_idx != 3'd7)
            bit_idx <= bit_idx + 3'd1;
         if (state == S_DATA && expiry)
            shift <= {rx_s, shift[7:1]};
         if (dv_nxt)
            data_q <= shift;
      end
   end

   assign bus.data_out   = data_q;
   assign bus.data_valid = dv_q;
   assign bus.frame_err  = fe_q;
   assign bus.busy       = busy_c;

endmodule
